// File: rtl/ysyx_23060187_lsu_pkg.sv
// Shared types and lane helpers for the load/store unit and its alignment datapath.
package ysyx_23060187_lsu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned MASK_W = XLEN / 8;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_X = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Access attributes held for the lifetime of one request.
  typedef struct packed {
    logic       wen;
    size_e      size;
    logic       sgn;
    logic [1:0] off;
  } lsu_req_t;

  function automatic logic [MASK_W-1:0] lane_mask(input size_e sz, input logic [1:0] off);
    logic [MASK_W-1:0] m;
    case (sz)
      SZ_B:    m = 4'b0001 << off;
      SZ_H:    m = 4'b0011 << off;
      SZ_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [4:0] lane_shamt(input logic [1:0] off);
    return {off, 3'b000};
  endfunction

  function automatic logic misaligned(input size_e sz, input logic [1:0] off);
    logic bad;
    case (sz)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = (off != 2'd0);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ysyx_23060187_lsu_align.sv
// Combinational byte-lane datapath: store mask/shift, load extract/extend, legality.
module ysyx_23060187_lsu_align
  import ysyx_23060187_lsu_pkg::*;
(
  input  size_e             size,
  input  logic              sgn,
  input  logic [1:0]        off,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [MASK_W-1:0] wmask_c,
  output logic [XLEN-1:0]   wdata_c,
  output logic [XLEN-1:0]   rdata_c,
  output logic              misalign_c
);

  logic [XLEN-1:0] rsh;

  always_comb begin
    wmask_c    = lane_mask(size, off);
    wdata_c    = wdata << lane_shamt(off);
    misalign_c = misaligned(size, off);
    rsh        = rdata >> lane_shamt(off);
    case (size)
      SZ_B:    rdata_c = {{24{sgn & rsh[7]}}, rsh[7:0]};
      SZ_H:    rdata_c = {{16{sgn & rsh[15]}}, rsh[15:0]};
      default: rdata_c = rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_23060187_lsu.sv
// Multi-cycle load/store unit: one request from execute onto a valid/ready data bus.
module ysyx_23060187_lsu
  import ysyx_23060187_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [XLEN-1:0]     req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                resp_valid,
  output logic [XLEN-1:0]     resp_rdata,
  output logic                resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [XLEN-1:0]     mem_addr,
  output logic                mem_wen,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [MASK_W-1:0]   mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [XLEN-1:0]     mem_rdata
);

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  state_e            state_q, state_d;
  lsu_req_t          req_q, req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic              mem_wen_q, mem_wen_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [MASK_W-1:0] mem_wmask_q, mem_wmask_d;

  // The aligner sees the incoming request in IDLE and the held request afterwards.
  logic              sel_in;
  size_e             al_size;
  logic              al_sgn;
  logic [1:0]        al_off;
  logic [MASK_W-1:0] al_wmask;
  logic [XLEN-1:0]   al_wdata;
  logic [XLEN-1:0]   al_rdata;
  logic              al_misalign;
  logic              timeout_hit;

  always_comb begin
    sel_in  = (state_q == ST_IDLE);
    al_size = sel_in ? size_e'(req_size) : req_q.size;
    al_sgn  = sel_in ? req_signed : req_q.sgn;
    al_off  = sel_in ? req_addr[1:0] : req_q.off;
  end

  ysyx_23060187_lsu_align u_align (
    .size       (al_size),
    .sgn        (al_sgn),
    .off        (al_off),
    .wdata      (req_wdata),
    .rdata      (mem_rdata),
    .wmask_c    (al_wmask),
    .wdata_c    (al_wdata),
    .rdata_c    (al_rdata),
    .misalign_c (al_misalign)
  );

  assign timeout_hit = TO_EN && (cnt_q >= CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    state_d         = state_q;
    req_d           = req_q;
    cnt_d           = cnt_q;
    req_ready_d     = 1'b0;
    resp_valid_d    = 1'b0;
    resp_rdata_d    = '0;
    resp_err_d      = 1'b0;
    mem_req_valid_d = mem_req_valid_q;
    mem_addr_d      = mem_addr_q;
    mem_wen_d       = mem_wen_q;
    mem_wdata_d     = mem_wdata_q;
    mem_wmask_d     = mem_wmask_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d       = '0;
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_d       = '{wen: req_wen, size: size_e'(req_size), sgn: req_signed, off: req_addr[1:0]};
          req_ready_d = 1'b0;
          if (al_misalign) begin
            state_d      = ST_DONE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d         = ST_REQ;
            mem_req_valid_d = 1'b1;
            mem_addr_d      = {req_addr[31:2], 2'b00};
            mem_wen_d       = req_wen;
            mem_wdata_d     = req_wen ? al_wdata : '0;
            mem_wmask_d     = req_wen ? al_wmask : '0;
          end
        end
      end
      ST_REQ, ST_WAIT: begin
        cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        if (state_q == ST_REQ && mem_req_ready) begin
          state_d         = ST_WAIT;
          mem_req_valid_d = 1'b0;
        end else if (state_q == ST_WAIT && mem_resp_valid) begin
          state_d      = ST_DONE;
          resp_valid_d = 1'b1;
          resp_rdata_d = req_q.wen ? '0 : al_rdata;
        end else if (timeout_hit) begin
          state_d         = ST_DONE;
          mem_req_valid_d = 1'b0;
          resp_valid_d    = 1'b1;
          resp_err_d      = 1'b1;
        end
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        cnt_d       = '0;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      req_q           <= '0;
      cnt_q           <= '0;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= '0;
      resp_err_q      <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      mem_wen_q       <= 1'b0;
      mem_wdata_q     <= '0;
      mem_wmask_q     <= '0;
    end else begin
      state_q         <= state_d;
      req_q           <= req_d;
      cnt_q           <= cnt_d;
      req_ready_q     <= req_ready_d;
      resp_valid_q    <= resp_valid_d;
      resp_rdata_q    <= resp_rdata_d;
      resp_err_q      <= resp_err_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_addr_q      <= mem_addr_d;
      mem_wen_q       <= mem_wen_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_wmask_q     <= mem_wmask_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_err      = resp_err_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wen       = mem_wen_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wmask     = mem_wmask_q;

endmodule

// File: tb/tb_ysyx_23060187_lsu.sv
// Bench for the LSU: directed and random accesses against a byte-level reference model.
module tb_ysyx_23060187_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_wen, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, mem_rdata;
  logic        req_ready, resp_valid, resp_err, mem_req_valid, mem_wen;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_req_ready, mem_resp_valid;

  logic        t_req_ready, t_resp_valid, t_resp_err, t_mem_req_valid, t_mem_wen;
  logic [31:0] t_resp_rdata, t_mem_addr, t_mem_wdata;
  logic [3:0]  t_mem_wmask;
  logic        t_mem_req_ready, t_mem_resp_valid;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ysyx_23060187_lsu u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  ysyx_23060187_lsu #(.TIMEOUT_CYCLES(4), .CNT_W(8)) u_dut_to (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(t_req_ready), .req_wen(req_wen),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(t_resp_valid), .resp_rdata(t_resp_rdata), .resp_err(t_resp_err),
    .mem_req_valid(t_mem_req_valid), .mem_req_ready(t_mem_req_ready), .mem_addr(t_mem_addr),
    .mem_wen(t_mem_wen), .mem_wdata(t_mem_wdata), .mem_wmask(t_mem_wmask),
    .mem_resp_valid(t_mem_resp_valid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic int nbytes_of(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_illegal(input logic [1:0] size, input logic [1:0] off);
    if (size == 2'd3) return 1'b1;
    return (int'(off) % nbytes_of(size)) != 0;
  endfunction

  function automatic logic [3:0] model_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m = '0;
    for (int b = 0; b < 4; b++)
      m[b] = (b >= int'(off)) && (b < int'(off) + nbytes_of(size));
    return m;
  endfunction

  // Gathers the accessed bytes little-endian, then applies two's-complement extension.
  function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn,
                                             input logic [1:0] off, input logic [31:0] word);
    int     n = nbytes_of(size);
    longint v = 0;
    for (int b = 0; b < n; b++)
      v += longint'((word >> (8 * (int'(off) + b))) & 32'hFF) << (8 * b);
    if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v -= (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  task automatic run_access(input logic wen, input logic [1:0] size, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rword, input int rdy_dly, input int rsp_dly);
    logic [1:0] off = addr[1:0];
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_wen = wen; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
    if (model_illegal(size, off)) begin
      chk("ill_resp_valid", 32'(resp_valid), 32'd1);
      chk("ill_resp_err", 32'(resp_err), 32'd1);
      chk("ill_rdata", resp_rdata, 32'd0);
      chk("ill_no_bus", 32'(mem_req_valid), 32'd0);
      @(negedge clk);
      chk("ill_pulse_end", 32'(resp_valid), 32'd0);
      chk("ill_ready_back", 32'(req_ready), 32'd1);
      return;
    end
    chk("req_valid_up", 32'(mem_req_valid), 32'd1);
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
    chk("mem_wen", 32'(mem_wen), 32'(wen));
    chk("mem_wmask", 32'(mem_wmask), wen ? 32'(model_mask(size, off)) : 32'd0);
    if (wen) chk("mem_wdata", mem_wdata, wdata << (8 * int'(off)));
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk);
      chk("bp_valid_stable", 32'(mem_req_valid), 32'd1);
      chk("bp_addr_stable", mem_addr, {addr[31:2], 2'b00});
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("req_valid_drop", 32'(mem_req_valid), 32'd0);
    for (int j = 0; j < rsp_dly; j++) begin
      @(negedge clk);
      chk("wait_no_resp", 32'(resp_valid), 32'd0);
    end
    mem_resp_valid = 1'b1; mem_rdata = rword;
    @(negedge clk);
    mem_resp_valid = 1'b0; mem_rdata = $urandom;
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_err", 32'(resp_err), 32'd0);
    chk("resp_rdata", resp_rdata, wen ? 32'd0 : model_load(size, sgn, off, rword));
    @(negedge clk);
    chk("pulse_end", 32'(resp_valid), 32'd0);
    chk("ready_back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    t_mem_req_ready = 1'b0; t_mem_resp_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_mem_wen", 32'(mem_wen), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wmask", 32'(mem_wmask), 32'd0);

    // Directed cases from the plan.
    run_access(1'b1, 2'd0, 1'b0, 32'h8000_0003, 32'h0000_00AB, 32'h0, 0, 0);
    run_access(1'b0, 2'd1, 1'b1, 32'h8000_0002, 32'h0, 32'h8001_1234, 0, 0);
    run_access(1'b0, 2'd1, 1'b0, 32'h8000_0002, 32'h0, 32'h8001_1234, 1, 2);
    run_access(1'b0, 2'd2, 1'b0, 32'h8000_0001, 32'h0, 32'h0, 0, 0);
    run_access(1'b1, 2'd3, 1'b0, 32'h8000_0000, 32'h1234_5678, 32'h0, 0, 0);
    run_access(1'b1, 2'd2, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 5, 1);
    run_access(1'b0, 2'd0, 1'b1, 32'h8000_0001, 32'h0, 32'h0000_8000, 0, 0);

    for (int k = 0; k < 40; k++)
      run_access(1'($urandom), 2'($urandom), 1'($urandom), 32'h8000_0000 | 32'($urandom_range(0, 4095)),
                 $urandom, $urandom, int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));

    // Reset while waiting for the read response.
    req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd2; req_addr = 32'h8000_0100;
    @(negedge clk);
    req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw_req_ready", 32'(req_ready), 32'd1);
    chk("rstw_resp_valid", 32'(resp_valid), 32'd0);
    chk("rstw_mem_req_valid", 32'(mem_req_valid), 32'd0);
    mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("stray_resp_ignored", 32'(resp_valid), 32'd0);
    chk("stray_ready", 32'(req_ready), 32'd1);

    // Reset while the bus request is still pending.
    req_valid = 1'b1; req_wen = 1'b1; req_size = 2'd2; req_addr = 32'h8000_0200;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstq_req_up", 32'(mem_req_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstq_req_dropped", 32'(mem_req_valid), 32'd0);
    chk("rstq_ready", 32'(req_ready), 32'd1);
    run_access(1'b0, 2'd2, 1'b0, 32'h8000_0204, 32'h0, 32'h1357_9BDF, 0, 0);

    // Timeout instance: no response at all.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd2; req_addr = 32'h8000_0040;
    @(negedge clk);
    req_valid = 1'b0;
    chk("to_req_up", 32'(t_mem_req_valid), 32'd1);
    repeat (4) @(negedge clk);
    chk("to_still_pending", 32'(t_mem_req_valid), 32'd1);
    chk("to_no_resp_yet", 32'(t_resp_valid), 32'd0);
    @(negedge clk);
    chk("to_resp_valid", 32'(t_resp_valid), 32'd1);
    chk("to_resp_err", 32'(t_resp_err), 32'd1);
    chk("to_rdata_zero", t_resp_rdata, 32'd0);
    chk("to_req_dropped", 32'(t_mem_req_valid), 32'd0);
    @(negedge clk);
    chk("to_pulse_end", 32'(t_resp_valid), 32'd0);
    chk("to_ready_back", 32'(t_req_ready), 32'd1);

    // Timeout instance: response lands exactly on the final count.
    req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd0; req_signed = 1'b1; req_addr = 32'h8000_0043;
    @(negedge clk);
    req_valid = 1'b0; t_mem_req_ready = 1'b1;
    @(negedge clk);
    t_mem_req_ready = 1'b0;
    chk("tol_in_wait", 32'(t_mem_req_valid), 32'd0);
    repeat (3) @(negedge clk);
    t_mem_resp_valid = 1'b1; mem_rdata = 32'h9A00_0000;
    @(negedge clk);
    t_mem_resp_valid = 1'b0;
    chk("tol_resp_valid", 32'(t_resp_valid), 32'd1);
    chk("tol_resp_err", 32'(t_resp_err), 32'd0);
    chk("tol_rdata", t_resp_rdata, model_load(2'd0, 1'b1, 2'd3, 32'h9A00_0000));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ysyx_23060187_lsu.md
Name: ysyx_23060187_lsu

Overview:
Multi-cycle load/store unit between the execute stage and data memory. It replaces the combinational data port of the single-cycle core. It takes one load or store request from execute and drives a valid/ready memory bus with a word-aligned address, byte mask and lane-shifted data. It returns zero- or sign-extended load data, or a completion/error pulse, to the writeback logic, which stalls the pc until the pulse arrives.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in REQ+WAIT before the access aborts with an error; 0 disables the timeout.
CNT_W, 8, width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2**CNT_W.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  execute presents an access.
req_ready  out  1  LSU can accept; high only in IDLE.
req_wen  in  1  1 = store, 0 = load.
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
req_signed  in  1  loads only: 1 = sign-extend (lb/lh), 0 = zero-extend (lbu/lhu).
req_addr  in  32  byte address (src1+imm).
req_wdata  in  32  store data, right-aligned (src2).
resp_valid  out  1  one-cycle completion pulse.
resp_rdata  out  32  extended load data; 0 for stores and errors.
resp_err  out  1  qualifies resp_valid: misaligned, illegal size or timeout.
mem_req_valid  out  1  bus request.
mem_req_ready  in  1  bus accepts the request.
mem_addr  out  32  {addr[31:2],2'b00}.
mem_wen  out  1  bus write.
mem_wdata  out  32  store data shifted to its byte lane.
mem_wmask  out  4  byte enables; 0 for reads.
mem_resp_valid  in  1  read data or write ack.
mem_rdata  in  32  full aligned word.

Behaviour:
- Reset: state=IDLE. req_ready=1. resp_valid, resp_err, mem_req_valid, mem_wen=0. resp_rdata, mem_addr, mem_wdata, mem_wmask=0. Counter=0.
- Reset mid-access: returns to IDLE the next cycle and drops mem_req_valid without waiting for mem_req_ready. Any later mem_resp_valid is ignored while in IDLE.
- FSM IDLE→REQ→WAIT→DONE→IDLE. All outputs are registered.
- IDLE: on req_valid&&req_ready, latch wen, size, signed, addr[1:0] (off) and wdata.
  - Legality check: half needs off[0]=0; word needs off=0; size 3 is illegal.
  - Illegal access: go to DONE with err=1 and make no bus access.
  - Legal access: go to REQ and start counting.
- REQ: mem_req_valid=1. addr, wen, wdata and mask stay stable until mem_req_ready. On handshake, go to WAIT and drop mem_req_valid next cycle.
- WAIT: on mem_resp_valid, capture mem_rdata and go to DONE. mem_resp_valid is sampled only in WAIT; the bus guarantees a response at least 1 cycle after the request handshake.
- DONE: resp_valid=1 for exactly one cycle, then IDLE. req_ready=1 the following cycle. Minimum legal latency from accept to resp_valid is 3 cycles.
- Store mask: byte 4'b0001<<off; half 4'b0011<<off; word 4'b1111.
- Store data: mem_wdata=req_wdata<<(8*off).
- Load: sh=mem_rdata>>(8*off). Byte uses sh[7:0] and half uses sh[15:0], each extended per signed; word passes through unchanged.
- Timeout: the counter increments each cycle in REQ or WAIT and clears on entering IDLE. When the count equals TIMEOUT_CYCLES (nonzero) and no handshake or response occurs that cycle, go to DONE with err=1 and drop mem_req_valid. If a handshake or response coincides with the final count, the access completes normally.
- Simultaneous events: req_valid while not IDLE is ignored (req_ready=0). resp_valid and the next acceptance never share a cycle.

Decomposition:
- Shared package ysyx_23060187_lsu_pkg:
  - size encodings SZ_B/SZ_H/SZ_W;
  - FSM state enum;
  - mask/shift helper functions.
- One sub-module, ysyx_23060187_lsu_align: purely combinational. It generates the mask, store shift, load extract/extend and misalignment flag, and is reusable by the fetch unit.

Test Plan:
- Byte store: req_wen=1, size=0, addr=0x8000_0003, wdata=0x0000_00AB → mem_addr=0x8000_0000, wmask=4'b1000, mem_wdata=0xAB00_0000; resp_valid pulse, err=0.
- Signed half load: addr=0x8000_0002, mem_rdata=0x8001_1234 → resp_rdata=0xFFFF_8001. With signed=0 → 0x0000_8001.
- Misaligned: word load at 0x8000_0001 → no mem_req_valid, resp_valid 1 cycle after accept, err=1, rdata=0.
- Backpressure: mem_req_ready low for 5 cycles → mem_req_valid and mem_addr stable throughout; completion follows the eventual handshake.
- Timeout: TIMEOUT_CYCLES=4, no mem_resp_valid → resp_err=1 on the cycle after count hits 4. A response arriving on the 4th count instead completes with err=0.
- Reset during WAIT → req_ready=1 the next cycle, no resp_valid, and a stray mem_resp_valid is ignored.
